// File: rtl/out_port_alloc_if.sv
// Handshake bundle between one router output allocator and its input ports.
// The master side drives requests and credits. The slave side (the allocator) drives grants and forwarding.
interface out_port_alloc_if #(
    parameter int NUM_IN = 5,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 3
);
    logic [NUM_IN-1:0] req_i;
    logic [NUM_IN-1:0] valid_i;
    logic [NUM_IN-1:0] tail_i;
    logic              credit_ret_i;

    logic [NUM_IN-1:0] grant_o;
    logic [SEL_W-1:0]  sel_o;
    logic              fwd_o;
    logic              busy_o;
    logic [CNT_W-1:0]  credit_o;
    logic              cred_err_o;

    modport master (
        output req_i, valid_i, tail_i, credit_ret_i,
        input  grant_o, sel_o, fwd_o, busy_o, credit_o, cred_err_o
    );

    modport slave (
        input  req_i, valid_i, tail_i, credit_ret_i,
        output grant_o, sel_o, fwd_o, busy_o, credit_o, cred_err_o
    );
endinterface

// File: rtl/out_port_alloc.sv
// Output-port allocator for a 5-port wormhole router. It uses round-robin arbitration and holds
// the lock for the whole packet. Flit forwarding is gated by downstream credits.
module out_port_alloc #(
    parameter int NUM_IN       = 5,
    parameter int CREDIT_DEPTH = 4,
    parameter int SEL_W        = 3,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    out_port_alloc_if.slave  bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDIT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [SEL_W-1:0] PTR_RESET  = SEL_W'(NUM_IN - 1);

    state_t            state_reg;
    logic [NUM_IN-1:0] grant_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic [SEL_W-1:0]  rr_ptr_reg;
    logic [CNT_W-1:0]  credit_reg;
    logic [CNT_W-1:0]  credit_next;
    logic              cred_err_reg;
    logic              cred_err_next;

    logic              owner_valid;
    logic              owner_tail;
    logic              fwd;
    logic              release_pkt;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic [NUM_IN-1:0] pick_onehot;

    // grant_reg is one-hot while locked, so masking picks out the owner's bits without indexing.
    assign owner_valid = |(bus.valid_i & grant_reg);
    assign owner_tail  = |(bus.tail_i & grant_reg);
    assign fwd         = (state_reg == LOCKED) && owner_valid && (credit_reg != '0);
    assign release_pkt = fwd && owner_tail;

    // Scan downward so that the closest requester after rr_ptr is the last one written and wins.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int off = NUM_IN; off >= 1; off--) begin
            idx = (int'(rr_ptr_reg) + off) % NUM_IN;
            if (bus.req_i[idx]) begin
                pick_found = 1'b1;
                pick_idx   = SEL_W'(idx);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_onehot
            assign pick_onehot[gi] = pick_found && (pick_idx == SEL_W'(gi));
        end
    endgenerate

    // A credit return and a forward in the same cycle cancel out. A return at full count saturates the counter and flags an error.
    always_comb begin
        credit_next   = credit_reg;
        cred_err_next = cred_err_reg;
        case ({bus.credit_ret_i, fwd})
            2'b10: begin
                if (credit_reg == CREDIT_MAX) begin
                    cred_err_next = 1'b1;
                end else begin
                    credit_next = credit_reg + CNT_ONE;
                end
            end
            2'b01:   credit_next = credit_reg - CNT_ONE;
            default: credit_next = credit_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            sel_reg      <= '0;
            rr_ptr_reg   <= PTR_RESET;
            credit_reg   <= CREDIT_MAX;
            cred_err_reg <= 1'b0;
        end else begin
            credit_reg   <= credit_next;
            cred_err_reg <= cred_err_next;
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        grant_reg <= pick_onehot;
                        sel_reg   <= pick_idx;
                        state_reg <= LOCKED;
                    end
                end
                LOCKED: begin
                    // req_i is ignored while locked. Only a forwarded tail flit releases the output.
                    if (release_pkt) begin
                        grant_reg  <= '0;
                        rr_ptr_reg <= sel_reg;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.grant_o    = grant_reg;
    assign bus.sel_o      = sel_reg;
    assign bus.fwd_o      = fwd;
    assign bus.busy_o     = (state_reg == LOCKED);
    assign bus.credit_o   = credit_reg;
    assign bus.cred_err_o = cred_err_reg;
endmodule

// File: tb/tb_out_port_alloc.sv
// Directed scoreboard bench for out_port_alloc. Each expected grant and forwarded-flit owner is queued.
// A negedge monitor checks them, and status outputs are checked inline.
module tb_out_port_alloc;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    int   exp_grant_q[$];
    int   exp_fwd_q[$];
    logic [4:0] prev_grant;

    out_port_alloc_if #(.NUM_IN(5), .SEL_W(3), .CNT_W(3)) bus ();

    out_port_alloc #(
        .NUM_IN(5), .CREDIT_DEPTH(4), .SEL_W(3), .CNT_W(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic set_in(input logic [4:0] req, input logic [4:0] valid, input logic [4:0] tail);
        bus.req_i   = req;
        bus.valid_i = valid;
        bus.tail_i  = tail;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(5'b0, 5'b0, 5'b0);
        bus.credit_ret_i = 1'b0;
        step(2);
        rst = 1'b0;
        check("rst_grant", 32'(bus.grant_o), 32'd0);
        check("rst_sel", 32'(bus.sel_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_credit", 32'(bus.credit_o), 32'd4);
        check("rst_cred_err", 32'(bus.cred_err_o), 32'd0);
        check("rst_fwd", 32'(bus.fwd_o), 32'd0);
    endtask

    // Monitor: pop an expectation whenever a new grant appears or a flit is forwarded.
    always @(negedge clk) begin : monitor
        int e;
        logic [4:0] oh;
        if (rst) begin
            prev_grant = 5'b0;
        end else begin
            if (bus.grant_o != 5'b0 && bus.grant_o != prev_grant) begin
                compared++;
                if (exp_grant_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL grant_unexpected: got %b, required no new grant", bus.grant_o);
                end else begin
                    e  = exp_grant_q.pop_front();
                    oh = 5'(1 << e);
                    if (bus.grant_o !== oh || bus.sel_o !== 3'(e)) begin
                        mismatched++;
                        $display("FAIL grant: got grant=%b sel=%0d, required grant=%b sel=%0d",
                                 bus.grant_o, bus.sel_o, oh, e);
                    end else begin
                        $display("ok   grant: input %0d", e);
                    end
                end
            end
            if (bus.fwd_o) begin
                compared++;
                if (exp_fwd_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL fwd_unexpected: got flit from sel=%0d, required none", bus.sel_o);
                end else begin
                    e  = exp_fwd_q.pop_front();
                    oh = 5'(1 << e);
                    if (bus.grant_o !== oh || bus.sel_o !== 3'(e)) begin
                        mismatched++;
                        $display("FAIL fwd_owner: got grant=%b sel=%0d, required input %0d",
                                 bus.grant_o, bus.sel_o, e);
                    end else begin
                        $display("ok   fwd: flit from input %0d", e);
                    end
                end
            end
            prev_grant = bus.grant_o;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        prev_grant = 5'b0;
        rst = 1'b1;
        set_in(5'b0, 5'b0, 5'b0);
        bus.credit_ret_i = 1'b0;

        // 1: a 3-flit packet from input 0, then a single flit from input 2 after one bubble cycle.
        do_reset();
        exp_grant_q.push_back(0);
        repeat (3) exp_fwd_q.push_back(0);
        exp_grant_q.push_back(2);
        exp_fwd_q.push_back(2);
        set_in(5'b00101, 5'b00101, 5'b00100);
        step(1);
        check("t1_busy", 32'(bus.busy_o), 32'd1);
        step(2);
        bus.tail_i = 5'b00101;
        step(1);
        check("t1_bubble_grant", 32'(bus.grant_o), 32'd0);
        check("t1_bubble_busy", 32'(bus.busy_o), 32'd0);
        set_in(5'b00100, 5'b00100, 5'b00100);
        step(1);
        check("t1_sel2", 32'(bus.sel_o), 32'd2);
        step(1);
        set_in(5'b0, 5'b0, 5'b0);
        check("t1_credit", 32'(bus.credit_o), 32'd0);
        check("t1_sel_hold", 32'(bus.sel_o), 32'd2);

        // 2: all inputs request single-flit packets. Grants go 0,1,2,3,4,0 with bubble cycles between them.
        do_reset();
        foreach (exp_grant_q[i]) ;
        for (int k = 0; k < 6; k++) begin
            exp_grant_q.push_back(k % 5);
            exp_fwd_q.push_back(k % 5);
        end
        set_in(5'b11111, 5'b11111, 5'b11111);
        for (int n = 1; n <= 12; n++) begin
            step(1);
            check($sformatf("t2_busy_c%0d", n), 32'(bus.busy_o), 32'(n % 2));
            bus.credit_ret_i = (n % 2 == 1);
            if (n == 12) set_in(5'b0, 5'b0, 5'b0);
        end
        check("t2_credit", 32'(bus.credit_o), 32'd4);
        check("t2_cred_err", 32'(bus.cred_err_o), 32'd0);

        // 3: credit stall. Four flits go out, then one more after a single credit return.
        do_reset();
        exp_grant_q.push_back(3);
        repeat (5) exp_fwd_q.push_back(3);
        set_in(5'b01000, 5'b01000, 5'b00000);
        step(5);
        check("t3_credit_empty", 32'(bus.credit_o), 32'd0);
        check("t3_fwd_stall", 32'(bus.fwd_o), 32'd0);
        step(1);
        bus.credit_ret_i = 1'b1;
        step(1);
        bus.credit_ret_i = 1'b0;
        check("t3_credit_one", 32'(bus.credit_o), 32'd1);
        check("t3_fwd_one", 32'(bus.fwd_o), 32'd1);
        step(1);
        check("t3_credit_zero", 32'(bus.credit_o), 32'd0);
        check("t3_fwd_zero", 32'(bus.fwd_o), 32'd0);
        step(2);
        check("t3_fwd_still_zero", 32'(bus.fwd_o), 32'd0);
        check("t3_busy", 32'(bus.busy_o), 32'd1);

        // 4: a forward and a credit return in the same cycle leave the count unchanged. A return at full count saturates and sets a sticky error.
        do_reset();
        exp_grant_q.push_back(1);
        repeat (7) exp_fwd_q.push_back(1);
        set_in(5'b00010, 5'b00010, 5'b00000);
        step(2);
        for (int i = 0; i < 4; i++) begin
            step(1);
            bus.credit_ret_i = 1'b1;
            check($sformatf("t4_credit_hold%0d", i), 32'(bus.credit_o), 32'd2);
        end
        step(1);
        check("t4_credit_hold4", 32'(bus.credit_o), 32'd2);
        bus.tail_i = 5'b00010;
        step(1);
        check("t4_released", 32'(bus.busy_o), 32'd0);
        check("t4_credit_after", 32'(bus.credit_o), 32'd2);
        set_in(5'b0, 5'b0, 5'b0);
        step(2);
        check("t4_credit_full", 32'(bus.credit_o), 32'd4);
        check("t4_no_err_yet", 32'(bus.cred_err_o), 32'd0);
        step(1);
        bus.credit_ret_i = 1'b0;
        check("t4_credit_sat", 32'(bus.credit_o), 32'd4);
        check("t4_err_set", 32'(bus.cred_err_o), 32'd1);
        step(3);
        check("t4_err_sticky", 32'(bus.cred_err_o), 32'd1);

        // 5: the lock holds while the owner drops req/valid and input 3 requests.
        do_reset();
        exp_grant_q.push_back(1);
        repeat (2) exp_fwd_q.push_back(1);
        exp_grant_q.push_back(3);
        exp_fwd_q.push_back(3);
        set_in(5'b00010, 5'b00010, 5'b00000);
        step(2);
        set_in(5'b01000, 5'b01000, 5'b00000);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t5_lock_grant%0d", i), 32'(bus.grant_o), 32'b00010);
            step(1);
        end
        set_in(5'b01010, 5'b01010, 5'b00010);
        step(1);
        set_in(5'b01000, 5'b01000, 5'b01000);
        step(1);
        check("t5_grant3", 32'(bus.grant_o), 32'b01000);
        step(1);
        set_in(5'b0, 5'b0, 5'b0);

        // 6: asynchronous reset mid-packet, then a fresh grant to input 4.
        do_reset();
        exp_grant_q.push_back(0);
        repeat (3) exp_fwd_q.push_back(0);
        set_in(5'b00001, 5'b00001, 5'b00000);
        step(4);
        check("t6_credit_one", 32'(bus.credit_o), 32'd1);
        check("t6_busy", 32'(bus.busy_o), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_async_grant", 32'(bus.grant_o), 32'd0);
        check("t6_async_busy", 32'(bus.busy_o), 32'd0);
        check("t6_async_credit", 32'(bus.credit_o), 32'd4);
        set_in(5'b0, 5'b0, 5'b0);
        step(1);
        rst = 1'b0;
        exp_grant_q.push_back(4);
        set_in(5'b10000, 5'b00000, 5'b00000);
        step(1);
        check("t6_grant4", 32'(bus.grant_o), 32'b10000);
        set_in(5'b0, 5'b0, 5'b0);
        step(2);

        check("left_grants", 32'(exp_grant_q.size()), 32'd0);
        check("left_fwds", 32'(exp_fwd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
